reg_write_sequencer: RTL and testbench

//  Shares the register file's single write port (dest/data/wen) among NUM_REQ writeback sources, e.g. ALU, load, SP adjust.

---
 rtl/reg_write_sequencer.sv | 145 ++++++++++++++
 tb/tb_reg_write_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/reg_write_sequencer.sv
// Round-robin arbiter that shares the register file's single write port.
// Each legal write is sequenced SETUP/STROBE/HOLD so latch-based storage sees a clean wen pulse.
module reg_write_sequencer #(
  parameter int NUM_REQ = 3,
  parameter int MAX_REG = 17,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [5*NUM_REQ-1:0]   req_dest_in,
  input  logic [32*NUM_REQ-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [4:0]             reg_dest_out,
  output logic [31:0]            reg_data_out,
  output logic                   reg_wen_out,
  output logic                   busy_out,
  output logic                   err_out,
  input  logic                   err_clr_in,
  output logic [CNT_W-1:0]       wr_count_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] MAX_R = 5'(MAX_REG);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [4:0]       dest_q, dest_d;
  logic [31:0]      data_q, data_d;
  logic             wen_q, wen_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]  dest_a [NUM_REQ];
  logic [31:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dest_a[i] = req_dest_in[5*i +: 5];
    assign data_a[i] = req_data_in[32*i +: 32];
  end

  logic          window, gnt_vld, fire, legal, err_set;
  logic [IW-1:0] gnt_idx, scan_idx;
  logic [4:0]    sel_dest;
  logic [31:0]   sel_data;
  int            scan;

  // Rotating priority scan starting just after the last granted requester.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan     = 0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan     = (int'(last_q) + k) % NUM_REQ;
      scan_idx = IW'(scan);
      if (!gnt_vld && req_valid_in[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // rst gates the grant so nothing is acknowledged during a reset cycle.
  assign window   = !rst && (state_q == S_IDLE || state_q == S_HOLD);
  assign fire     = window && gnt_vld;
  assign sel_dest = dest_a[gnt_idx];
  assign sel_data = data_a[gnt_idx];
  assign legal    = (sel_dest != 5'd0) && (sel_dest <= MAX_R);

  always_comb begin
    req_ready_out = '0;
    if (fire) req_ready_out[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dest_d  = dest_q;
    data_d  = data_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        state_d = S_IDLE;
        if (fire) begin
          dest_d = sel_dest;
          data_d = sel_data;
          last_d = gnt_idx;
          if (legal) state_d = S_SETUP;
          else       err_set = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        wen_d   = 1'b1;
      end
      S_STROBE: begin
        state_d = S_HOLD;
        wen_d   = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETUP) || (state_d == S_STROBE);
    err_d  = err_set ? 1'b1 : (err_clr_in ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      dest_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_dest_out = dest_q;
  assign reg_data_out = data_q;
  assign reg_wen_out  = wen_q;
  assign busy_out     = busy_q;
  assign err_out      = err_q;
  assign wr_count_out = cnt_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Random requesters against a transaction-timeline model of the write sequencer.
// The model tracks when the next grant may occur and when each wen pulse is due.
module tb_reg_write_sequencer;
  localparam int N    = 3;
  localparam int MAXR = 17;
  localparam int CW   = 4;
  localparam int CYCLES = 4000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid_in = '1;
  logic [5*N-1:0]  req_dest_in = '0;
  logic [32*N-1:0] req_data_in = '0;
  logic [N-1:0]    req_ready_out;
  logic [4:0]      reg_dest_out;
  logic [31:0]     reg_data_out;
  logic            reg_wen_out, busy_out, err_out;
  logic            err_clr_in = 1'b0;
  logic [CW-1:0]   wr_count_out;

  always #5 clk = ~clk;

  reg_write_sequencer #(.NUM_REQ(N), .MAX_REG(MAXR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_dest_in(req_dest_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out),
    .reg_dest_out(reg_dest_out), .reg_data_out(reg_data_out), .reg_wen_out(reg_wen_out),
    .busy_out(busy_out), .err_out(err_out), .err_clr_in(err_clr_in),
    .wr_count_out(wr_count_out)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: grant timeline plus architectural results.
  int          m_last, m_next_ok, m_legal_k, m_wen_cyc, m_cnt;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_mem [32];
  logic [31:0] d_mem [32];

  bit          act  [N];
  logic [4:0]  rd   [N];
  logic [31:0] rdat [N];

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset(input int cyc);
    m_last = N - 1; m_next_ok = cyc + 1; m_legal_k = -10; m_wen_cyc = -10;
    m_dest = '0; m_data = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  initial begin
    int g, r;
    bit forced_strobe_rst;
    logic [N-1:0] exp_ready;
    forced_strobe_rst = 0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; d_mem[i] = '0; end
    for (int i = 0; i < N; i++) begin act[i] = 0; rd[i] = '0; rdat[i] = '0; end
    model_reset(0);
    m_next_ok = 0;

    for (int cyc = 1; cyc <= CYCLES; cyc++) begin
      @(posedge clk); #1;
      // Stimulus for this cycle.
      rst = (cyc <= 2) || ($urandom_range(0, 299) == 0)
            || (cyc == m_wen_cyc && $urandom_range(0, 29) == 0);
      if (!forced_strobe_rst && cyc > 100 && cyc == m_wen_cyc) begin
        rst = 1'b1;
        forced_strobe_rst = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (!act[i] && (cyc <= 2 || $urandom_range(0, 2) == 0)) begin
          act[i] = 1;
          r = $urandom_range(0, 9);
          if (r == 0)      rd[i] = 5'd0;
          else if (r == 1) rd[i] = 5'($urandom_range(MAXR + 1, 31));
          else             rd[i] = 5'($urandom_range(1, MAXR));
          rdat[i] = $urandom;
        end
        req_valid_in[i]        = act[i];
        req_dest_in[5*i +: 5]  = rd[i];
        req_data_in[32*i +: 32] = rdat[i];
      end
      err_clr_in = ($urandom_range(0, 7) == 0);

      @(negedge clk);
      g = -1;
      exp_ready = '0;
      if (!rst && cyc >= m_next_ok) begin
        g = rr_pick(m_last, req_valid_in);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("ready", 64'(req_ready_out), 64'(exp_ready));
      check("wen",   64'(reg_wen_out), 64'(cyc == m_wen_cyc));
      check("busy",  64'(busy_out), 64'(cyc == m_legal_k + 1 || cyc == m_legal_k + 2));
      check("dest",  64'(reg_dest_out), 64'(m_dest));
      check("data",  64'(reg_data_out), 64'(m_data));
      check("err",   64'(err_out), 64'(m_err));
      check("count", 64'(wr_count_out), 64'(m_cnt));

      if (reg_wen_out === 1'b1) d_mem[reg_dest_out] = reg_data_out;
      for (int i = 0; i < N; i++)
        if (req_valid_in[i] && req_ready_out[i]) act[i] = 0;

      // Advance model across the coming edge.
      if (cyc == m_wen_cyc) begin
        m_mem[m_dest] = m_data;
        if (!rst) m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (rst) begin
        model_reset(cyc);
      end else begin
        bit set;
        set = 0;
        if (g >= 0) begin
          m_dest = rd[g];
          m_data = rdat[g];
          m_last = g;
          if (rd[g] >= 1 && rd[g] <= MAXR) begin
            m_legal_k = cyc; m_wen_cyc = cyc + 2; m_next_ok = cyc + 3;
          end else begin
            set = 1; m_next_ok = cyc + 1;
          end
        end
        m_err = set ? 1'b1 : (err_clr_in ? 1'b0 : m_err);
      end
    end

    for (int i = 0; i < 32; i++) check($sformatf("regfile[%0d]", i), 64'(d_mem[i]), 64'(m_mem[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
